mul_div_iter: RTL and testbench
===============================

// Module: mul_div_iter
// PURPOSE
//  Iterative multiply/divide unit for the E stage: signed/unsigned MULT and DIV producing a
//  HI/LO pair. Replaces the fixed 32-bit multiplier/divider inside the ALU path. Parametrised
//  in operand width and in bits retired per cycle (radix). Adds cancel (exception flush), a
//  divide-by-zero flag, and a DONE hold for when the pipeline cannot advance.
// PARAMETERS
//  WIDTH  32  operand width; hi/lo are each WIDTH bits
//  BPC    1   bits retired per cycle (1,2,4,8; must divide WIDTH); ITER = WIDTH/BPC
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active-low
//  start        in   1      E-stage instruction is a mult/div; held high while stalled
//  op           in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a            in   WIDTH  rs operand (multiplicand / dividend)
//  b            in   WIDTH  rt operand (multiplier / divisor)
//  cancel       in   1      flush; abandons any operation in flight
//  advance      in   1      E stage will advance this cycle (no other stall source)
//  stall        out  1      combinational; feeds hazard unit as mut_div_stallE
//  busy         out  1      state != IDLE
//  done         out  1      result valid (state == DONE)
//  hi           out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
//  lo           out  WIDTH  MULT: product[W-1:0]; DIV: quotient
//  div_by_zero  out  1      valid with done; set for DIV/DIVU with b == 0
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, counter=0, hi=lo=0, done=0, div_by_zero=0.
//  States IDLE -> CALC -> DONE -> IDLE.
//  IDLE: start=1 & cancel=0 -> latch |a|, |b| (abs for signed ops only), result signs and op;
//   counter=0; go CALC. Exception: DIV/DIVU with b==0 goes straight to DONE.
//  CALC: each cycle performs BPC shift-add (mult) or BPC restoring-subtract (div) steps and
//   increments counter. On the cycle counter==ITER-1, apply the sign fix-ups, register the
//   result into hi/lo, and go DONE.
//  DONE: done=1. hi/lo are already valid. Go IDLE when advance=1, else stay in DONE.
//   A new op is never accepted in DONE.
//  stall = start & (state==IDLE | state==CALC) & ~cancel. stall is 0 in DONE.
//  Latency: start seen in IDLE at cycle 0; DONE at cycle ITER+1. stall is high for ITER+1
//   cycles (33 for WIDTH=32, BPC=1; 9 for BPC=4).
//  Sign rules:
//   - MULT: product negated if sign(a) != sign(b).
//   - DIV: quotient negated if the signs differ; remainder takes the sign of a.
//   - DIV of most-negative by -1: lo = 0x8000_0000, hi = 0 (falls out of the magnitude
//     arithmetic; no special case).
//  Divide by zero: lo = all ones, hi = a, div_by_zero=1 in DONE. Reached one cycle after start.
//  cancel=1 in any state -> IDLE next cycle; hi/lo keep prior values; done=0.
//   cancel wins over start in the same cycle.
//  hi/lo change only on entry to DONE. They hold across IDLE/CALC until the next completion.
//  div_by_zero is cleared on leaving DONE.
//  Widths: internal product accumulator is 2*WIDTH; the divider partial remainder is WIDTH+1.
//  Reset asserted mid-CALC: immediate return to IDLE with all outputs at reset values.
// TESTING
//  MULT a=FFFFFFFF b=00000002 -> done at cycle 33, hi=FFFFFFFF lo=FFFFFFFE, stall high 33 cycles
//  MULTU a=FFFFFFFF b=00000002 -> hi=00000001 lo=FFFFFFFE
//  DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD hi=FFFFFFFF; DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0
//  DIVU a=7 b=0 -> done at cycle 1, div_by_zero=1, lo=FFFFFFFF hi=00000007
//  cancel at CALC cycle 10 -> IDLE next cycle, hi/lo unchanged; advance=0 in DONE holds done for 3 cycles
//  BPC=4, MULTU a=12345678 b=9ABCDEF0 -> done at cycle 9, hi=0B00EA4E lo=242D2080; rst low mid-CALC -> all outputs 0

Source files
------------

// File: rtl/mul_div_if.sv
// ============================================================================
// Module   : mul_div_if
// Purpose  : E-stage request/result bundle for the iterative multiply/divide unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             advance;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, cancel, advance,
    input  stall, busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, cancel, advance,
    output stall, busy, done, hi, lo, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/mul_div_iter.sv
// ============================================================================
// Module   : mul_div_iter
// Purpose  : Iterative signed/unsigned MULT/DIV producing HI/LO, BPC bits per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_div_iter #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic     clk,
  input  logic     rst,
  mul_div_if.slave bus
);

  localparam int ITER = WIDTH / BPC;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(ITER - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dbz;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic               w_div_zero;
  logic               w_last;
  logic               w_stall;
  logic               w_busy;
  logic               w_done;

  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH:0]     w_t;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_signed   = ~bus.op[0];
  assign w_a_neg    = w_signed & bus.a[WIDTH-1];
  assign w_b_neg    = w_signed & bus.b[WIDTH-1];
  assign w_a_abs    = w_a_neg ? -bus.a : bus.a;
  assign w_b_abs    = w_b_neg ? -bus.b : bus.b;
  assign w_div_zero = bus.op[1] & (bus.b == '0);
  assign w_last     = (r_cnt == c_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.cancel) begin
      w_state_next = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:  if (bus.start) w_state_next = w_div_zero ? c_DONE : c_CALC;
        c_CALC:  if (w_last) w_state_next = c_DONE;
        c_DONE:  if (bus.advance) w_state_next = c_IDLE;
        default: w_state_next = c_IDLE;
      endcase
    end
  end

  always_comb begin
    w_stall = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      c_IDLE: w_stall = bus.start & ~bus.cancel;
      c_CALC: begin
        w_stall = bus.start & ~bus.cancel;
        w_busy  = 1'b1;
      end
      c_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Mult: low half holds the multiplier and shifts right as product bits arrive.
  // Div: low half holds the dividend and fills with quotient bits; high half is the remainder.
  always_comb begin
    w_acc_next = r_acc;
    w_t        = '0;
    w_diff     = '0;
    w_sum      = '0;
    for (int i = 0; i < BPC; i++) begin
      if (r_is_div) begin
        w_t    = {w_acc_next[2*WIDTH-1:WIDTH], w_acc_next[WIDTH-1]};
        w_diff = w_t - {1'b0, r_opnd};
        if (!w_diff[WIDTH]) begin
          w_acc_next = {w_diff[WIDTH-1:0], w_acc_next[WIDTH-2:0], 1'b1};
        end else begin
          w_acc_next = {w_t[WIDTH-1:0], w_acc_next[WIDTH-2:0], 1'b0};
        end
      end else begin
        w_sum      = {1'b0, w_acc_next[2*WIDTH-1:WIDTH]}
                   + (w_acc_next[0] ? {1'b0, r_opnd} : '0);
        w_acc_next = {w_sum, w_acc_next[WIDTH-1:1]};
      end
    end
  end

  assign w_prod   = r_neg_q ? -w_acc_next : w_acc_next;
  assign w_quo    = w_acc_next[WIDTH-1:0];
  assign w_rem    = w_acc_next[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_is_div ? (r_neg_q ? -w_quo : w_quo) : w_prod[WIDTH-1:0];
  assign w_res_hi = r_is_div ? (r_neg_r ? -w_rem : w_rem) : w_prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dbz    <= 1'b0;
    end else if (bus.cancel) begin
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            r_cnt    <= '0;
            r_is_div <= bus.op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            if (bus.op[1]) begin
              r_acc  <= {{WIDTH{1'b0}}, w_a_abs};
              r_opnd <= w_b_abs;
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, w_b_abs};
              r_opnd <= w_a_abs;
            end
            // Divide by zero completes immediately with the dividend in hi.
            if (w_div_zero) begin
              r_hi  <= bus.a;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end
          end
        end
        c_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
          end
        end
        c_DONE: begin
          if (bus.advance) r_dbz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.stall       = w_stall;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_iter.sv
// ============================================================================
// Module   : tb_mul_div_iter
// Purpose  : Self-checking bench for mul_div_iter at BPC=1 and BPC=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_iter;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mul_div_if #(.WIDTH(W)) m1();
  mul_div_if #(.WIDTH(W)) m4();

  mul_div_iter #(.WIDTH(W), .BPC(1)) u_dut1 (.clk(clk), .rst(rst), .bus(m1));
  mul_div_iter #(.WIDTH(W), .BPC(4)) u_dut4 (.clk(clk), .rst(rst), .bus(m4));

  // Reference: 64-bit arithmetic straight from the operation definitions; returns {dbz, hi, lo}.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sa = longint'($signed(a));
    longint     sb = longint'($signed(b));
    longint     q;
    longint     r;
    logic [63:0] p;
    logic [64:0] res;
    res = '0;
    case (op)
      2'd0: begin p = sa * sb; res = {1'b0, p}; end
      2'd1: begin p = {32'b0, a} * {32'b0, b}; res = {1'b0, p}; end
      default: begin
        if (b == 32'd0) begin
          res = {1'b1, a, 32'hFFFF_FFFF};
        end else if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          res = {1'b0, r[31:0], q[31:0]};
        end else begin
          res = {1'b0, a % b, a / b};
        end
      end
    endcase
    return res;
  endfunction

  task automatic drive(input bit sel, input logic st, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic cn, input logic adv);
    if (sel) begin
      m4.start = st; m4.op = op; m4.a = a; m4.b = b; m4.cancel = cn; m4.advance = adv;
    end else begin
      m1.start = st; m1.op = op; m1.a = a; m1.b = b; m1.cancel = cn; m1.advance = adv;
    end
  endtask

  // Issues one op, holds start until done, optionally holds DONE, then advances.
  task automatic run_op(input bit sel, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output int cycles, output int stalls,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz, output int held);
    cycles = 0; stalls = 0; held = 0;
    @(negedge clk);
    drive(sel, 1'b1, op, a, b, 1'b0, 1'b0);
    forever begin
      #1;
      if (sel ? m4.stall : m1.stall) stalls++;
      if ((sel ? m4.done : m1.done) || cycles > 200) break;
      @(negedge clk);
      cycles++;
    end
    hi  = sel ? m4.hi : m1.hi;
    lo  = sel ? m4.lo : m1.lo;
    dbz = sel ? m4.div_by_zero : m1.div_by_zero;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      if ((sel ? m4.done : m1.done) && (sel ? m4.hi : m1.hi) == hi && (sel ? m4.lo : m1.lo) == lo
          && !(sel ? m4.stall : m1.stall))
        held++;
    end
    @(negedge clk);
    drive(sel, 1'b0, op, a, b, 1'b0, 1'b1);
    @(negedge clk);
    drive(sel, 1'b0, op, a, b, 1'b0, 1'b0);
  endtask

  logic [31:0] last_hi, last_lo;

  task automatic test_reset;
    #1;
    n_checks++;
    if ({m1.stall, m1.busy, m1.done, m1.div_by_zero, m1.hi, m1.lo} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b dbz=%b hi=%h lo=%h, want all zero",
               m1.busy, m1.done, m1.div_by_zero, m1.hi, m1.lo);
    end
  endtask

  task automatic test_directed;
    logic [1:0]  ops [5]  = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [31:0] va  [5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
    logic [31:0] vb  [5]  = '{32'd2, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] ehi [5]  = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd7};
    logic [31:0] elo [5]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    logic        edz [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          elat [5] = '{33, 33, 33, 33, 1};
    int cyc, stl, held;
    logic [31:0] hi, lo;
    logic dbz;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, ops[i], va[i], vb[i], 0, cyc, stl, hi, lo, dbz, held);
      n_checks++;
      if ({dbz, hi, lo} !== {edz[i], ehi[i], elo[i]}) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got dbz=%b hi=%h lo=%h, want dbz=%b hi=%h lo=%h",
                 i, dbz, hi, lo, edz[i], ehi[i], elo[i]);
      end
      n_checks++;
      if (cyc !== elat[i] || stl !== elat[i]) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got done@%0d stall=%0d, want %0d/%0d",
                 i, cyc, stl, elat[i], elat[i]);
      end
    end
    n_checks++;
    #1;
    if (m1.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL dbz_clear: got %b want 0", m1.div_by_zero);
    end
    last_hi = ehi[4];
    last_lo = elo[4];
  endtask

  task automatic test_done_hold;
    int cyc, stl, held;
    logic [31:0] hi, lo;
    logic dbz;
    logic [64:0] exp;
    exp = model(2'd0, 32'h0000_1234, 32'hFFFF_FF00);
    run_op(1'b0, 2'd0, 32'h0000_1234, 32'hFFFF_FF00, 3, cyc, stl, hi, lo, dbz, held);
    n_checks++;
    if (held !== 3 || {dbz, hi, lo} !== exp) begin
      n_fail++;
      $display("FAIL done_hold: got held=%0d hi=%h lo=%h, want held=3 hi=%h lo=%h",
               held, hi, lo, exp[63:32], exp[31:0]);
    end
    last_hi = exp[63:32];
    last_lo = exp[31:0];
  endtask

  task automatic test_cancel;
    @(negedge clk);
    drive(1'b0, 1'b1, 2'd1, $urandom, $urandom, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    n_checks++;
    if (m1.busy !== 1'b1 || m1.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL cancel_precond: got busy=%b stall=%b want 1/1", m1.busy, m1.stall);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd1, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({m1.busy, m1.done, m1.hi, m1.lo} !== {2'b00, last_hi, last_lo}) begin
      n_fail++;
      $display("FAIL cancel_calc: got busy=%b done=%b hi=%h lo=%h, want 0 0 hi=%h lo=%h",
               m1.busy, m1.done, m1.hi, m1.lo, last_hi, last_lo);
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 2'd3, 32'd9, 32'd0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (m1.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_stall: got stall=%b want 0", m1.stall);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({m1.busy, m1.done, m1.div_by_zero} !== 3'b000) begin
      n_fail++;
      $display("FAIL cancel_wins: got busy=%b done=%b dbz=%b want 000", m1.busy, m1.done, m1.div_by_zero);
    end
  endtask

  task automatic test_random(input bit sel, input int n);
    int cyc, stl, held, elat;
    logic [31:0] hi, lo, a, b;
    logic [1:0] op;
    logic dbz;
    logic [64:0] exp;
    for (int i = 0; i < n; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = -32'($urandom_range(1, 300));
        default: ;
      endcase
      exp  = model(op, a, b);
      elat = exp[64] ? 1 : (sel ? 9 : 33);
      run_op(sel, op, a, b, 0, cyc, stl, hi, lo, dbz, held);
      n_checks++;
      if ({dbz, hi, lo} !== exp || cyc !== elat || stl !== elat) begin
        n_fail++;
        $display("FAIL random[%0d] bpc%0d op=%0d a=%h b=%h: got dbz=%b hi=%h lo=%h lat=%0d stall=%0d, want dbz=%b hi=%h lo=%h lat=%0d",
                 i, sel ? 4 : 1, op, a, b, dbz, hi, lo, cyc, stl, exp[64], exp[63:32], exp[31:0], elat);
      end
    end
  endtask

  task automatic test_bpc4;
    int cyc, stl, held;
    logic [31:0] hi, lo;
    logic dbz;
    run_op(1'b1, 2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0, cyc, stl, hi, lo, dbz, held);
    n_checks++;
    if ({dbz, hi, lo} !== {1'b0, 32'h0B00_EA4E, 32'h242D_2080} || cyc !== 9 || stl !== 9) begin
      n_fail++;
      $display("FAIL bpc4_multu: got hi=%h lo=%h lat=%0d stall=%0d, want hi=0b00ea4e lo=242d2080 lat=9 stall=9",
               hi, lo, cyc, stl);
    end
  endtask

  task automatic test_reset_mid_calc;
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd0, 32'hDEAD_BEEF, 32'h0000_0123, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({m4.stall, m4.busy, m4.done, m4.div_by_zero, m4.hi, m4.lo} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_calc: got stall=%b busy=%b done=%b dbz=%b hi=%h lo=%h, want all zero",
               m4.stall, m4.busy, m4.done, m4.div_by_zero, m4.hi, m4.lo);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b1;
    test_directed;
    test_done_hold;
    test_cancel;
    test_random(1'b0, 30);
    test_bpc4;
    test_random(1'b1, 20);
    test_reset_mid_calc;
    test_random(1'b1, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
